// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencing logic.
package multdiv_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      INIT = 2'b01,
      ITER = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic [1:0] ALU_NOP = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter for the multiply/divide sequencer.
// The clear input wins over enable, so a restart always begins at zero.
module multdiv_iter_counter
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   // Count register: synchronous clear has priority over increment.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing FSM for the shared multiply/divide datapath.
// Runs a Booth multiply or a non-restoring divide over WIDTH iterations.
// A new start in any state aborts the current operation.
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [1:0]       booth_bits,
   input  logic             rem_sign,
   input  logic             divisor_zero,
   output logic             prod_in_enable,
   output logic             prod_out_enable,
   output logic             load_init,
   output logic [1:0]       alu_op,
   output logic             is_div,
   output logic [CNT_W-1:0] count,
   output logic             data_resultRDY,
   output logic             data_exception
);

   state_t state;
   state_t next_state;
   logic   start;
   logic   cnt_enable;
   logic   terminal;
   logic   div_by_zero;

   assign start       = ctrl_MULT | ctrl_DIV;
   assign div_by_zero = (state == INIT) && is_div && divisor_zero;

   multdiv_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (start),
      .enable   (cnt_enable),
      .count    (count),
      .terminal (terminal)
   );

   // State, operation type and the registered completion flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         is_div         <= 1'b0;
         data_resultRDY <= 1'b0;
         data_exception <= 1'b0;
      end else begin
         state          <= next_state;
         data_resultRDY <= (next_state == DONE);
         data_exception <= (next_state == DONE) && div_by_zero;
         if (start) begin
            is_div <= ~ctrl_MULT;
         end
      end
   end

   // Next-state decode and per-cycle datapath controls; a start overrides everything.
   always_comb begin
      next_state     = state;
      prod_in_enable = 1'b0;
      load_init      = 1'b0;
      alu_op         = ALU_NOP;
      cnt_enable     = 1'b0;
      unique case (state)
         IDLE: begin
            next_state = IDLE;
         end
         INIT: begin
            prod_in_enable = 1'b1;
            load_init      = 1'b1;
            next_state     = div_by_zero ? DONE : ITER;
         end
         ITER: begin
            prod_in_enable = 1'b1;
            cnt_enable     = ~terminal;
            if (is_div) begin
               alu_op = rem_sign ? ALU_ADD : ALU_SUB;
            end else begin
               unique case (booth_bits)
                  2'b01:   alu_op = ALU_ADD;
                  2'b10:   alu_op = ALU_SUB;
                  default: alu_op = ALU_NOP;
               endcase
            end
            next_state = terminal ? DONE : ITER;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (start) begin
         next_state = INIT;
      end
   end

   assign prod_out_enable = (state == DONE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed testbench for multdiv_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
module tb_multdiv_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       ctrl_MULT;
   logic       ctrl_DIV;
   logic [1:0] booth_bits;
   logic       rem_sign;
   logic       divisor_zero;
   logic       prod_in_enable;
   logic       prod_out_enable;
   logic       load_init;
   logic [1:0] alu_op;
   logic       is_div;
   logic [4:0] count;
   logic       data_resultRDY;
   logic       data_exception;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   multdiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
      .clock           (clock),
      .reset           (reset),
      .ctrl_MULT       (ctrl_MULT),
      .ctrl_DIV        (ctrl_DIV),
      .booth_bits      (booth_bits),
      .rem_sign        (rem_sign),
      .divisor_zero    (divisor_zero),
      .prod_in_enable  (prod_in_enable),
      .prod_out_enable (prod_out_enable),
      .load_init       (load_init),
      .alu_op          (alu_op),
      .is_div          (is_div),
      .count           (count),
      .data_resultRDY  (data_resultRDY),
      .data_exception  (data_exception)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Pulse a start for one cycle; returns positioned in the INIT cycle, settled.
   task automatic start_op(input logic m, input logic d);
      tick();
      ctrl_MULT = m;
      ctrl_DIV  = d;
      tick();
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      #2;
   endtask

   // Reset state: every output low, counter at zero.
   task automatic test_reset();
      reset = 1'b1; ctrl_MULT = 0; ctrl_DIV = 0; booth_bits = 0; rem_sign = 0; divisor_zero = 0;
      tick(); tick();
      #2;
      total++;
      if ({prod_in_enable, prod_out_enable, load_init, alu_op, is_div, count, data_resultRDY, data_exception} !== 13'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got %b expected all zero",
                  {prod_in_enable, prod_out_enable, load_init, alu_op, is_div, count, data_resultRDY, data_exception});
      end
      tick();
      reset = 1'b0;
   endtask

   // Multiply with booth_bits 00: INIT, 32 NOP iterations, DONE at cycle 34, then IDLE.
   task automatic test_mult_nop();
      booth_bits = 2'b00;
      start_op(1'b1, 1'b0);
      total++;
      if (load_init !== 1'b1 || prod_in_enable !== 1'b1 || is_div !== 1'b0 || data_resultRDY !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mult_init: got li=%b pie=%b div=%b rdy=%b expected 1 1 0 0", load_init, prod_in_enable, is_div, data_resultRDY);
      end
      for (int i = 0; i < 32; i++) begin
         tick(); #2;
         total++;
         if (alu_op !== 2'b00 || prod_in_enable !== 1'b1 || load_init !== 1'b0 || count !== 5'(i) ||
             data_resultRDY !== 1'b0 || prod_out_enable !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mult_nop_iter%0d: got op=%0d pie=%b li=%b cnt=%0d rdy=%b poe=%b expected 0 1 0 %0d 0 0",
                     i, alu_op, prod_in_enable, load_init, count, data_resultRDY, prod_out_enable, i);
         end
      end
      tick(); #2;
      total++;
      if (data_resultRDY !== 1'b1 || prod_out_enable !== 1'b1 || data_exception !== 1'b0 || prod_in_enable !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mult_done: got rdy=%b poe=%b exc=%b pie=%b expected 1 1 0 0", data_resultRDY, prod_out_enable, data_exception, prod_in_enable);
      end
      tick(); #2;
      total++;
      if (data_resultRDY !== 1'b0 || prod_out_enable !== 1'b0 || prod_in_enable !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mult_idle_after: got rdy=%b poe=%b pie=%b expected 0 0 0", data_resultRDY, prod_out_enable, prod_in_enable);
      end
   endtask

   // Booth decode: 01 ADD, 10 SUB, 11 NOP, 00 NOP, with count stepping 0..31.
   task automatic test_mult_booth();
      logic [1:0] pattern  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
      logic [1:0] expected [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
      start_op(1'b1, 1'b0);
      for (int i = 0; i < 32; i++) begin
         tick();
         booth_bits = pattern[i % 4];
         #2;
         total++;
         if (alu_op !== expected[i % 4] || count !== 5'(i)) begin
            bad++;
            $display("[TB] FAIL booth_iter%0d: got op=%0d cnt=%0d expected op=%0d cnt=%0d", i, alu_op, count, expected[i % 4], i);
         end
      end
      booth_bits = 2'b00;
      tick(); #2;
      total++;
      if (data_resultRDY !== 1'b1 || data_exception !== 1'b0) begin
         bad++;
         $display("[TB] FAIL booth_done: got rdy=%b exc=%b expected 1 0", data_resultRDY, data_exception);
      end
   endtask

   // Divide by zero: INIT then DONE with exception at cycle 2, no iterations.
   task automatic test_div_zero();
      tick();
      ctrl_DIV = 1'b1;
      tick();
      ctrl_DIV     = 1'b0;
      divisor_zero = 1'b1;
      #2;
      total++;
      if (load_init !== 1'b1 || prod_in_enable !== 1'b1 || is_div !== 1'b1 || data_resultRDY !== 1'b0) begin
         bad++;
         $display("[TB] FAIL divz_init: got li=%b pie=%b div=%b rdy=%b expected 1 1 1 0", load_init, prod_in_enable, is_div, data_resultRDY);
      end
      tick(); #2;
      total++;
      if (data_resultRDY !== 1'b1 || data_exception !== 1'b1 || prod_in_enable !== 1'b0 || prod_out_enable !== 1'b1) begin
         bad++;
         $display("[TB] FAIL divz_done: got rdy=%b exc=%b pie=%b poe=%b expected 1 1 0 1", data_resultRDY, data_exception, prod_in_enable, prod_out_enable);
      end
      divisor_zero = 1'b0;
      tick(); #2;
      total++;
      if (data_resultRDY !== 1'b0 || data_exception !== 1'b0 || prod_in_enable !== 1'b0) begin
         bad++;
         $display("[TB] FAIL divz_idle: got rdy=%b exc=%b pie=%b expected 0 0 0", data_resultRDY, data_exception, prod_in_enable);
      end
   endtask

   // Non-restoring divide: SUB when remainder positive, ADD when negative.
   task automatic test_div_sign();
      divisor_zero = 1'b0;
      start_op(1'b0, 1'b1);
      total++;
      if (is_div !== 1'b1 || load_init !== 1'b1) begin
         bad++;
         $display("[TB] FAIL div_init: got div=%b li=%b expected 1 1", is_div, load_init);
      end
      for (int i = 0; i < 32; i++) begin
         tick();
         rem_sign = (i % 3 == 1);
         #2;
         total++;
         if (alu_op !== ((i % 3 == 1) ? 2'b01 : 2'b10) || data_resultRDY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL div_iter%0d: got op=%0d rdy=%b expected op=%0d rdy=0", i, alu_op, data_resultRDY, (i % 3 == 1) ? 1 : 2);
         end
      end
      rem_sign = 1'b0;
      tick(); #2;
      total++;
      if (data_resultRDY !== 1'b1 || data_exception !== 1'b0 || prod_out_enable !== 1'b1) begin
         bad++;
         $display("[TB] FAIL div_done: got rdy=%b exc=%b poe=%b expected 1 0 1", data_resultRDY, data_exception, prod_out_enable);
      end
   endtask

   // Simultaneous starts pick multiply; a divide at count 10 restarts the operation.
   task automatic test_both_and_restart();
      booth_bits = 2'b01;
      start_op(1'b1, 1'b1);
      total++;
      if (is_div !== 1'b0) begin
         bad++;
         $display("[TB] FAIL both_is_div: got %b expected 0", is_div);
      end
      for (int i = 0; i <= 10; i++) begin
         tick(); #2;
         total++;
         if (alu_op !== 2'b01 || count !== 5'(i)) begin
            bad++;
            $display("[TB] FAIL both_iter%0d: got op=%0d cnt=%0d expected op=1 cnt=%0d", i, alu_op, count, i);
         end
      end
      ctrl_DIV = 1'b1;
      tick();
      ctrl_DIV = 1'b0;
      #2;
      total++;
      if (load_init !== 1'b1 || is_div !== 1'b1 || count !== 5'd0 || data_resultRDY !== 1'b0) begin
         bad++;
         $display("[TB] FAIL restart_init: got li=%b div=%b cnt=%0d rdy=%b expected 1 1 0 0", load_init, is_div, count, data_resultRDY);
      end
      for (int c = 2; c <= 33; c++) begin
         tick(); #2;
         total++;
         if (data_resultRDY !== 1'b0 || alu_op !== 2'b10) begin
            bad++;
            $display("[TB] FAIL restart_cycle%0d: got rdy=%b op=%0d expected rdy=0 op=2", c, data_resultRDY, alu_op);
         end
      end
      tick(); #2;
      total++;
      if (data_resultRDY !== 1'b1 || data_exception !== 1'b0) begin
         bad++;
         $display("[TB] FAIL restart_done: got rdy=%b exc=%b expected 1 0", data_resultRDY, data_exception);
      end
      booth_bits = 2'b00;
   endtask

   // Asynchronous reset mid-iteration clears outputs at once and stays idle after.
   task automatic test_async_reset();
      booth_bits = 2'b10;
      start_op(1'b1, 1'b0);
      for (int i = 0; i <= 15; i++) begin
         tick(); #2;
      end
      total++;
      if (count !== 5'd15 || alu_op !== 2'b10) begin
         bad++;
         $display("[TB] FAIL areset_pre: got cnt=%0d op=%0d expected 15 2", count, alu_op);
      end
      reset = 1'b1;
      #1;
      total++;
      if ({prod_in_enable, prod_out_enable, load_init, alu_op, is_div, count, data_resultRDY, data_exception} !== 13'd0) begin
         bad++;
         $display("[TB] FAIL areset_immediate: got %b expected all zero",
                  {prod_in_enable, prod_out_enable, load_init, alu_op, is_div, count, data_resultRDY, data_exception});
      end
      tick(); tick();
      reset = 1'b0;
      booth_bits = 2'b00;
      for (int i = 0; i < 40; i++) begin
         tick(); #2;
         total++;
         if (data_resultRDY !== 1'b0 || prod_in_enable !== 1'b0 || prod_out_enable !== 1'b0) begin
            bad++;
            $display("[TB] FAIL areset_idle%0d: got rdy=%b pie=%b poe=%b expected 0 0 0", i, data_resultRDY, prod_in_enable, prod_out_enable);
         end
      end
   endtask

   // Run every scenario in order and report.
   initial begin
      test_reset();
      test_mult_nop();
      test_mult_booth();
      test_div_zero();
      test_div_sign();
      test_both_and_restart();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing FSM for the shared 65-bit multiply/divide datapath: product/remainder register, adder/subtractor and shifter.
- Accepts a one-cycle multiply or divide start and runs WIDTH iterations.
- Drives the product register's input/output enables, initial-load select and ALU op each cycle.
- Signals result-ready or divide-by-zero exception; sits between the processor's execute stage and the datapath.

Parameters:
WIDTH, 32, operand width and number of iterations
CNT_W, 5, iteration counter width, equal to clog2(WIDTH)

Ports:
clock  input  1  single clock domain, rising edge
reset  input  1  asynchronous, active-high; forces IDLE
ctrl_MULT  input  1  one-cycle pulse: start signed multiply (radix-2 Booth)
ctrl_DIV  input  1  one-cycle pulse: start divide (non-restoring)
booth_bits  input  2  product register bits [1:0] (multiplier LSB, Booth extra bit)
rem_sign  input  1  sign bit of current partial remainder
divisor_zero  input  1  divisor operand equals 0, valid in cycle after start
prod_in_enable  output  1  write enable to product register
prod_out_enable  output  1  tristate drive enable of product register onto result bus
load_init  output  1  datapath muxes initial value (operands) into product register
alu_op  output  2  00 NOP/pass, 01 ADD, 10 SUB, 11 unused (never driven)
is_div  output  1  current operation is divide
count  output  CNT_W  iteration index
data_resultRDY  output  1  one-cycle pulse: result valid on bus this cycle
data_exception  output  1  divide by zero; valid with data_resultRDY

Behaviour:
- Reset (async, any time incl. mid-operation): state IDLE, count 0, is_div 0, all outputs 0. After release, first sampled start begins a fresh operation.
- States: IDLE, INIT, ITER, DONE.
- IDLE: all enables 0, alu_op NOP.
  - ctrl_MULT → INIT, is_div 0.
  - ctrl_DIV (and not ctrl_MULT) → INIT, is_div 1.
  - Both high in same cycle: multiply wins, divide dropped.
- INIT (1 cycle): load_init 1, prod_in_enable 1, count cleared to 0.
  - is_div and divisor_zero → DONE with exception flag set; no iterations.
  - Otherwise → ITER.
- ITER (WIDTH cycles, count 0..WIDTH-1): prod_in_enable 1, load_init 0.
  - Multiply: alu_op = ADD if booth_bits 01, SUB if 10, NOP if 00/11.
  - Divide: alu_op = SUB if rem_sign 0, ADD if rem_sign 1.
  - count increments each cycle; at count WIDTH-1 → DONE. Count never wraps inside an operation.
- DONE (1 cycle): prod_in_enable 0, prod_out_enable 1, data_resultRDY 1. data_exception 1 only if divide-by-zero path was taken. → IDLE.
- prod_out_enable is high only in DONE; otherwise the bus is released.
- Latency: start sampled at edge k → INIT cycle k+1, ITER k+2..k+WIDTH+1, DONE k+WIDTH+2 (34 for WIDTH=32). Divide-by-zero: DONE at k+2.
- Start while busy (INIT/ITER/DONE): abort current op, go to INIT next cycle with new is_div; no resultRDY for aborted op; exception flag cleared.
- data_exception and data_resultRDY are registered outputs; no combinational path from inputs to them.

Decomposition:
- Shared package multdiv_pkg:
  - state encoding (IDLE/INIT/ITER/DONE)
  - ALU op constants (ALU_NOP, ALU_ADD, ALU_SUB)
  - default WIDTH/CNT_W
- One sub-module, multdiv_iter_counter: CNT_W-bit counter with synchronous clear, enable and terminal-count output (count == WIDTH-1); same clock/reset.

Test Plan:
- Reset then ctrl_MULT pulse, booth_bits held 00 → load_init at cycle 1, 32 cycles alu_op NOP, data_resultRDY and prod_out_enable high exactly at cycle 34, data_exception 0, back to IDLE.
- Multiply with booth_bits driven 01, 10, 11, 00 across iterations → alu_op ADD, SUB, NOP, NOP same cycle; count steps 0..31.
- ctrl_DIV with divisor_zero 1 → resultRDY and data_exception both 1 at cycle 2, no ITER cycles, prod_in_enable high only during INIT.
- ctrl_DIV, divisor_zero 0, rem_sign toggled → alu_op SUB when rem_sign 0, ADD when 1; resultRDY at cycle 34, exception 0.
- ctrl_MULT and ctrl_DIV in same cycle → is_div 0, Booth op selection. ctrl_DIV at ITER count 10 → restart in INIT next cycle, is_div 1, resultRDY 34 cycles after second start only.
- reset asserted asynchronously at ITER count 15 → all outputs 0 immediately; after release no resultRDY until a new start.
